i2s_tdm_master: RTL and testbench

//  Parametrised successor to the fixed 2-slot I2S master. Serialises N receiver IQ slots to the MCU (DOUT)
//  and deserialises N transmit slots from the MCU (DIN), in I2S or TDM framing, for multi-receiver builds.

---
 rtl/i2s_tdm_pkg.sv | 26 ++
 rtl/i2s_tdm_master_bclk_gen.sv | 38 +++
 rtl/i2s_tdm_master.sv | 164 ++++++++++++++++
 tb/tb_i2s_tdm_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tdm_pkg.sv
// Shared constants and slot/bit mapping helpers for the I2S/TDM serial master.
package i2s_tdm_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_TDM = 1;

  // Data runs one BCLK behind the frame counter, so position 0 lands at count 1
  // and the last position wraps round to count 0 of the next frame.
  function automatic int unsigned delayed_pos(int unsigned cnt, int unsigned frame);
    return (cnt == 0) ? frame - 1 : cnt - 1;
  endfunction

  function automatic int unsigned slot_of(int unsigned pos, int unsigned slot_w);
    return pos / slot_w;
  endfunction

  function automatic int unsigned bit_of(int unsigned pos, int unsigned slot_w);
    return pos % slot_w;
  endfunction

  // Flat index into a packed frame (slot 0 in the LSBs), b counted from the MSB.
  function automatic int unsigned pack_idx(int unsigned slot, int unsigned b, int unsigned word_w);
    return slot * word_w + word_w - 1 - b;
  endfunction

endpackage

// File: rtl/i2s_tdm_master_bclk_gen.sv
// Bit-clock divider: free-running phase counter, registered BCLK and edge strobes.
module bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic rise_en,
  output logic fall_en
);

  localparam int DW = $clog2(BCLK_DIV);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;

  always_comb begin
    rise_en   = (div_cnt_q == DW'(BCLK_DIV / 2 - 1));
    fall_en   = (div_cnt_q == DW'(BCLK_DIV - 1));
    div_cnt_d = fall_en ? '0 : div_cnt_q + DW'(1);
    bclk_d    = bclk_q;
    if (rise_en) bclk_d = 1'b1;
    if (fall_en) bclk_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk = bclk_q;

endmodule

// File: rtl/i2s_tdm_master.sv
// Multi-slot I2S/TDM master: frames parallel slot words onto DOUT and
// reassembles DIN into parallel frames, generating BCLK and LRCLK/FS itself.
module i2s_tdm_master
  import i2s_tdm_pkg::*;
#(
  parameter int WORD_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int SLOTS    = 2,
  parameter int BCLK_DIV = 4,
  parameter int MODE     = 0
) (
  input  logic                    clk,
  input  logic                    _reset,
  input  logic [SLOTS*WORD_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [SLOTS*WORD_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    underrun,
  output logic                    BCLK,
  output logic                    LRCLK,
  input  logic                    DIN,
  output logic                    DOUT
);

  localparam int FRAME = SLOTS * SLOT_W;
  localparam int FW    = SLOTS * WORD_W;
  localparam int CNT_W = $clog2(FRAME);
  localparam int IDX_W = $clog2(FW);

  if (SLOT_W < WORD_W) begin : g_bad_slot_w
    $error("i2s_tdm_master: SLOT_W must be >= WORD_W");
  end
  if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_div
    $error("i2s_tdm_master: BCLK_DIV must be even and >= 2");
  end
  if (MODE == MODE_I2S && SLOTS != 2) begin : g_bad_i2s
    $error("i2s_tdm_master: I2S framing requires SLOTS == 2");
  end
  if (MODE == MODE_TDM && !(SLOTS == 2 || SLOTS == 4 || SLOTS == 8)) begin : g_bad_tdm
    $error("i2s_tdm_master: TDM framing requires SLOTS of 2, 4 or 8");
  end
  if (MODE != MODE_I2S && MODE != MODE_TDM) begin : g_bad_mode
    $error("i2s_tdm_master: MODE must be 0 or 1");
  end

  logic             rise_en, fall_en;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [FW-1:0]    hold_q, hold_d, tx_q, tx_d, rx_q, rx_d, out_data_q, out_data_d;
  logic             hold_full_q, hold_full_d;
  logic             out_valid_q, out_valid_d, underrun_q, underrun_d;
  logic             lrclk_q, lrclk_d, dout_q, dout_d;
  logic             fell_q, fell_d, primed_q, primed_d;
  int unsigned      tx_pos, tx_b, rx_pos, rx_b;
  logic             tx_bit;
  logic [IDX_W-1:0] rx_idx;

  bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk     (clk),
    .rst_n   (_reset),
    .bclk    (BCLK),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  assign bit_nxt = (bit_cnt_q == CNT_W'(FRAME - 1)) ? '0 : bit_cnt_q + CNT_W'(1);

  // DOUT looks ahead to the count being entered; DIN sampling uses the current count.
  always_comb begin
    tx_pos = delayed_pos(32'(bit_nxt), FRAME);
    tx_b   = bit_of(tx_pos, SLOT_W);
    tx_bit = 1'b0;
    if (tx_b < WORD_W) tx_bit = tx_q[IDX_W'(pack_idx(slot_of(tx_pos, SLOT_W), tx_b, WORD_W))];
    rx_pos = delayed_pos(32'(bit_cnt_q), FRAME);
    rx_b   = bit_of(rx_pos, SLOT_W);
    rx_idx = IDX_W'(pack_idx(slot_of(rx_pos, SLOT_W), rx_b, WORD_W));
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    underrun_d  = 1'b0;
    lrclk_d     = lrclk_q;
    dout_d      = dout_q;
    fell_d      = fell_q;
    primed_d    = primed_q;

    if (fall_en) begin
      bit_cnt_d = bit_nxt;
      dout_d    = tx_bit;
      fell_d    = 1'b1;
      lrclk_d   = (MODE == MODE_TDM) ? (bit_nxt == '0) : (bit_nxt >= CNT_W'(SLOT_W));
      // Frame start works on the pre-load holding state, so a same-clk load waits a frame.
      if (bit_nxt == '0) begin
        if (hold_full_q) begin
          tx_d        = hold_q;
          hold_full_d = 1'b0;
        end else begin
          underrun_d  = 1'b1;
        end
      end
    end

    if (in_valid && !hold_full_q) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    // The rise before the first fall carries no frame; the first real frame only primes.
    if (rise_en) begin
      if (rx_b < WORD_W) rx_d[rx_idx] = DIN;
      if (bit_cnt_q == '0 && fell_q) begin
        primed_d = 1'b1;
        if (primed_q) begin
          out_data_d  = rx_d;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      lrclk_q     <= 1'b0;
      dout_q      <= 1'b0;
      fell_q      <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      lrclk_q     <= lrclk_d;
      dout_q      <= dout_d;
      fell_q      <= fell_d;
      primed_q    <= primed_d;
    end
  end

  assign in_ready  = !hold_full_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;
  assign LRCLK     = lrclk_q;
  assign DOUT      = dout_q;

endmodule

// File: tb/tb_i2s_tdm_master.sv
// Loopback bench for i2s_tdm_master across I2S, 8-slot TDM and slow-BCLK builds.
module tb_i2s_tdm_master;

  localparam int WORD_W = 24;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [191:0] in_data;
  int           sel;
  bit           chk_en;

  int n_total = 0;
  int n_bad   = 0;
  int ov_cnt  = 0;
  int ur_cnt  = 0;

  // Active build parameters, mirrored from the selected instance
  int cfg_div, cfg_slots, cfg_slot_w, cfg_mode, frame;

  // Reference model state
  int           mt;
  logic         m_full;
  logic [191:0] m_hold, m_tx;
  logic         e_bclk, e_lr, e_dout, e_ov, e_ur, e_ready;
  logic [191:0] exp_q[$];

  logic rst_a, rst_b, rst_c, vld_a, vld_b, vld_c;
  logic rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, ur_a, ur_b, ur_c;
  logic bclk_a, bclk_b, bclk_c, lr_a, lr_b, lr_c, dout_a, dout_b, dout_c;
  logic [47:0]  od_a, od_c;
  logic [191:0] od_b;

  logic         m_bclk, m_lr, m_dout, m_ready, m_ov, m_ur;
  logic [191:0] m_od;

  assign rst_a = rst_n && (sel == 0);
  assign rst_b = rst_n && (sel == 1);
  assign rst_c = rst_n && (sel == 2);
  assign vld_a = in_valid && (sel == 0);
  assign vld_b = in_valid && (sel == 1);
  assign vld_c = in_valid && (sel == 2);

  i2s_tdm_master u_a (
    .clk(clk), ._reset(rst_a), .in_data(in_data[47:0]), .in_valid(vld_a), .in_ready(rdy_a),
    .out_data(od_a), .out_valid(ov_a), .underrun(ur_a), .BCLK(bclk_a), .LRCLK(lr_a),
    .DIN(dout_a), .DOUT(dout_a)
  );

  i2s_tdm_master #(.MODE(1), .SLOTS(8), .SLOT_W(24), .BCLK_DIV(2)) u_b (
    .clk(clk), ._reset(rst_b), .in_data(in_data), .in_valid(vld_b), .in_ready(rdy_b),
    .out_data(od_b), .out_valid(ov_b), .underrun(ur_b), .BCLK(bclk_b), .LRCLK(lr_b),
    .DIN(dout_b), .DOUT(dout_b)
  );

  i2s_tdm_master #(.BCLK_DIV(6)) u_c (
    .clk(clk), ._reset(rst_c), .in_data(in_data[47:0]), .in_valid(vld_c), .in_ready(rdy_c),
    .out_data(od_c), .out_valid(ov_c), .underrun(ur_c), .BCLK(bclk_c), .LRCLK(lr_c),
    .DIN(dout_c), .DOUT(dout_c)
  );

  always_comb begin
    m_bclk = bclk_a; m_lr = lr_a; m_dout = dout_a; m_ready = rdy_a;
    m_ov = ov_a; m_ur = ur_a; m_od = 192'(od_a);
    if (sel == 1) begin
      m_bclk = bclk_b; m_lr = lr_b; m_dout = dout_b; m_ready = rdy_b;
      m_ov = ov_b; m_ur = ur_b; m_od = od_b;
    end else if (sel == 2) begin
      m_bclk = bclk_c; m_lr = lr_c; m_dout = dout_c; m_ready = rdy_c;
      m_ov = ov_c; m_ur = ur_c; m_od = 192'(od_c);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0d)", tag, got, want, mt);
    end
  endtask

  // Timing derived from clocks since reset release: fall j lands on clk j*DIV,
  // and the bit count after fall j is j mod frame.
  task automatic model_edge();
    int   j, n, p, k, b;
    logic full_old;
    if (!rst_n) begin
      mt = 0; m_full = 1'b0; m_hold = '0; m_tx = '0;
      e_bclk = 1'b0; e_lr = 1'b0; e_dout = 1'b0; e_ov = 1'b0; e_ur = 1'b0;
      exp_q.delete();
    end else begin
      mt++;
      full_old = m_full;
      e_ov = 1'b0;
      e_ur = 1'b0;
      if ((mt - 1) % cfg_div == cfg_div / 2 - 1) begin
        j = (mt - 1) / cfg_div;
        e_ov = (j % frame == 0) && (j >= 2 * frame);
      end
      e_bclk = (mt % cfg_div) >= cfg_div / 2;
      if (mt % cfg_div == 0) begin
        j = mt / cfg_div;
        n = j % frame;
        p = (n + frame - 1) % frame;
        k = p / cfg_slot_w;
        b = p % cfg_slot_w;
        e_dout = (b < WORD_W) ? m_tx[k * WORD_W + WORD_W - 1 - b] : 1'b0;
        e_lr   = (cfg_mode == 1) ? (n == 0) : (n >= cfg_slot_w);
        if (n == 0) begin
          if (full_old) begin
            m_tx   = m_hold;
            m_full = 1'b0;
          end else begin
            e_ur = 1'b1;
          end
          exp_q.push_back(m_tx);
        end
      end
      if (in_valid && !full_old) begin
        m_hold = in_data;
        m_full = 1'b1;
      end
    end
    e_ready = !m_full;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    logic [191:0] want;
    @(negedge clk);
    if (chk_en) begin
      check("bclk",      192'(m_bclk),  192'(e_bclk));
      check("lrclk",     192'(m_lr),    192'(e_lr));
      check("dout",      192'(m_dout),  192'(e_dout));
      check("in_ready",  192'(m_ready), 192'(e_ready));
      check("out_valid", 192'(m_ov),    192'(e_ov));
      check("underrun",  192'(m_ur),    192'(e_ur));
      if (m_ov) begin
        ov_cnt++;
        if (exp_q.size() == 0) begin
          check("ov_queue_level", 192'(exp_q.size()), 192'(1));
        end else begin
          want = exp_q.pop_front();
          check("out_data", m_od, want);
        end
      end
      if (m_ur) ur_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_t(input int target);
    for (int g = 0; g < 200000 && mt < target; g++) step(1);
  endtask

  task automatic send(input logic [191:0] f);
    logic ok;
    logic acc;
    logic [191:0] mask;
    mask = (192'(1) << (cfg_slots * WORD_W)) - 192'(1);
    in_data  = f & mask;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      ok = m_ready;
      step(1);
      if (ok) begin
        acc = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check("send_accept", 192'(acc), 192'(1));
  endtask

  task automatic start_cfg(input int s);
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = s;
    case (s)
      1:       begin cfg_div = 2; cfg_slots = 8; cfg_slot_w = 24; cfg_mode = 1; end
      2:       begin cfg_div = 6; cfg_slots = 2; cfg_slot_w = 32; cfg_mode = 0; end
      default: begin cfg_div = 4; cfg_slots = 2; cfg_slot_w = 32; cfg_mode = 0; end
    endcase
    frame = cfg_slots * cfg_slot_w;
    step(3);
    chk_en = 1'b1;
    ov_cnt = 0;
    ur_cnt = 0;
    check("rst_in_ready", 192'(m_ready), 192'(1));
    check("rst_out_data", m_od, 192'(0));
    check("rst_bclk",     192'(m_bclk),  192'(0));
    check("rst_lrclk",    192'(m_lr),    192'(0));
    check("rst_dout",     192'(m_dout),  192'(0));
  endtask

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    in_data = '0;
    // Default I2S build: loopback, underrun repeat, same-clk load, reset mid-slot-1
    start_cfg(0);
    rst_n = 1'b1;
    send(192'({24'h123456, 24'hABCDEF}));
    check("rdy_drop", 192'(m_ready), 192'(0));
    wait_t(270);
    send(192'({24'h00FF00, 24'h800001}));
    wait_t(1023);
    send(192'({24'h5A5A5A, 24'hC3C3C3}));
    wait_t(1440);
    rst_n = 1'b0;
    step(1);
    check("midrst_out_data", m_od, 192'(0));
    check("midrst_in_ready", 192'(m_ready), 192'(1));
    check("midrst_bclk",     192'(m_bclk),  192'(0));
    step(2);
    rst_n = 1'b1;
    send(192'({24'h7FFFFF, 24'h000001}));
    wait_t(532);
    check("a_out_valid_count", 192'(ov_cnt), 192'(5));
    check("a_underrun_count",  192'(ur_cnt), 192'(3));

    // 8-slot TDM build with one-BCLK frame sync
    start_cfg(1);
    rst_n = 1'b1;
    send(rnd192());
    wait_t(394);
    send(rnd192());
    wait_t(1162);
    check("b_out_valid_count", 192'(ov_cnt), 192'(2));
    check("b_underrun_count",  192'(ur_cnt), 192'(1));

    // Slow bit clock: three clks high, three low
    start_cfg(2);
    rst_n = 1'b1;
    send(rnd192());
    wait_t(394);
    send(rnd192());
    wait_t(1162);
    check("c_out_valid_count", 192'(ov_cnt), 192'(2));
    check("c_underrun_count",  192'(ur_cnt), 192'(1));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
